// File: rtl/coax_host_bus_port.sv
// -----------------------------------------------------------------------------
// coax_host_bus_port
//
// Host-side bus port between the MCU's asynchronous shared data bus and the
// coax_tx / coax_buffered_rx cores. Contains:
//   - SYNC_STAGES-deep synchronisers on the three asynchronous host inputs,
//     with edge detection on the two strobes
//   - a TX_DEPTH-word transmit FIFO that paces one-clock loads into coax_tx
//   - a four-state bus-turnaround FSM that owns the pad output enable
//   - sticky overflow / underflow flags
//
// Optional feature macro: COAX_HOST_PORT_STATS_EN
//   Defined   -> adds tx_drop_count[7:0] and rx_underrun_count[7:0], saturating
//                event counters that follow tx_overflow / rx_underflow.
//   Undefined -> those ports and counters do not exist.
//
// Ports:
//   clk             core clock (38 MHz PLL domain)
//   reset           asynchronous, active-high reset
//   host_tx_load    async host write strobe (rising edge)
//   host_rx_read    async host read strobe (rising edge)
//   host_rx_enable  async bus-direction request (1 = port drives bus)
//   host_data_in    bus pad input word
//   host_data_out   bus pad output word
//   host_data_oe    bus pad output enable
//   host_tx_full    transmit FIFO full (registered)
//   host_rx_empty   registered copy of rx_empty
//   tx_overflow     sticky: a host load was dropped on a full FIFO
//   rx_underflow    sticky: a host read hit an empty receiver
//   rx_enable       synchronised host_rx_enable, to receiver gate
//   tx_data         word to coax_tx
//   tx_load         one-clock load pulse to coax_tx
//   tx_full         coax_tx full
//   rx_data         head word from coax_buffered_rx
//   rx_read_strobe  one-clock pop pulse to receiver
//   rx_empty        receiver empty
// -----------------------------------------------------------------------------
module coax_host_bus_port #(
    parameter int DATA_WIDTH        = 10,
    parameter int SYNC_STAGES       = 2,
    parameter int TX_DEPTH          = 16,
    parameter int TURNAROUND_CLOCKS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_tx_load,
    input  logic                  host_rx_read,
    input  logic                  host_rx_enable,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    output logic [DATA_WIDTH-1:0] host_data_out,
    output logic                  host_data_oe,
    output logic                  host_tx_full,
    output logic                  host_rx_empty,
    output logic                  tx_overflow,
    output logic                  rx_underflow,
    output logic                  rx_enable,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    input  logic                  tx_full,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_read_strobe,
    input  logic                  rx_empty
`ifdef COAX_HOST_PORT_STATS_EN
    ,
    output logic [7:0]            tx_drop_count,
    output logic [7:0]            rx_underrun_count
`endif
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TURNAROUND_CLOCKS + 1);
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(TX_DEPTH);
    localparam logic [CW-1:0] TA_LOAD    = CW'(TURNAROUND_CLOCKS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_TURN_ON  = 2'd1,
        ST_DRIVING  = 2'd2,
        ST_TURN_OFF = 2'd3
    } bus_state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers: bit 0 = write strobe, 1 = read strobe, 2 = enable
    // -------------------------------------------------------------------------
    logic [2:0] w_async;
    logic [2:0] w_sync_top;

    assign w_async = {host_rx_enable, host_rx_read, host_tx_load};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_async[gi]};
                end
            end

            assign w_sync_top[gi] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    // Edge-detect stage. The enable level is delayed by the same extra flop so
    // all three inputs see SYNC_STAGES+1 clocks of latency into the core.
    logic r_ld_dly, r_rd_dly;
    logic r_ld_ev, r_rd_ev;
    logic r_en_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_dly <= 1'b0;
            r_rd_dly <= 1'b0;
            r_ld_ev  <= 1'b0;
            r_rd_ev  <= 1'b0;
            r_en_lvl <= 1'b0;
        end else begin
            r_ld_dly <= w_sync_top[0];
            r_rd_dly <= w_sync_top[1];
            r_ld_ev  <= w_sync_top[0] & ~r_ld_dly;
            r_rd_ev  <= w_sync_top[1] & ~r_rd_dly;
            r_en_lvl <= w_sync_top[2];
        end
    end

    // -------------------------------------------------------------------------
    // Bus turnaround FSM
    // -------------------------------------------------------------------------
    bus_state_t    r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_oe;

    // The counter is loaded with TURNAROUND_CLOCKS on entry, so each turn
    // state lasts exactly TURNAROUND_CLOCKS clocks: leaving when it would
    // decrement to zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_RELEASED: begin
                if (r_en_lvl) begin
                    w_state_next = ST_TURN_ON;
                    w_cnt_next   = TA_LOAD;
                end
            end
            ST_TURN_ON: begin
                if (!r_en_lvl) begin
                    w_state_next = ST_TURN_OFF;
                    w_cnt_next   = TA_LOAD;
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_next = ST_DRIVING;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            ST_DRIVING: begin
                if (!r_en_lvl) begin
                    w_state_next = ST_TURN_OFF;
                    w_cnt_next   = TA_LOAD;
                end
            end
            ST_TURN_OFF: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_next = ST_RELEASED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_oe    <= (w_state_next == ST_DRIVING);
        end
    end

    logic w_released, w_driving;
    assign w_released = (r_state == ST_RELEASED);
    assign w_driving  = (r_state == ST_DRIVING);

    // -------------------------------------------------------------------------
    // Transmit FIFO
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [TX_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW:0]           r_count, w_count_next;
    logic                  r_host_full;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_load;
    logic                  w_push, w_drop, w_pop;

    // Loads arriving outside RELEASED are ignored outright (no drop flag).
    assign w_push = r_ld_ev & w_released & (r_count != FULL_COUNT);
    assign w_drop = r_ld_ev & w_released & (r_count == FULL_COUNT);
    // Blocking on the previous tx_load enforces the 2-clock load spacing.
    assign w_pop  = (r_count != '0) & ~tx_full & ~r_tx_load;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array without reset so it maps onto block RAM; contents are
    // discarded on reset by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= host_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_host_full <= 1'b0;
            r_tx_data   <= '0;
            r_tx_load   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_count     <= w_count_next;
            r_host_full <= (w_count_next == FULL_COUNT);
            r_tx_load   <= w_pop;
        end
    end

    // -------------------------------------------------------------------------
    // Receive path and sticky flags
    // -------------------------------------------------------------------------
    logic                  r_rd_strobe;
    logic                  r_underflow, r_overflow;
    logic                  r_host_rx_empty;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_underrun;

    assign w_underrun = r_rd_ev & w_driving & rx_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_strobe     <= 1'b0;
            r_underflow     <= 1'b0;
            r_overflow      <= 1'b0;
            r_host_rx_empty <= 1'b1;
            r_dout          <= '0;
        end else begin
            r_rd_strobe     <= r_rd_ev & w_driving & ~rx_empty;
            r_host_rx_empty <= rx_empty;
            if (w_underrun) begin
                r_underflow <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_driving) begin
                r_dout <= rx_data;
            end
        end
    end

`ifdef COAX_HOST_PORT_STATS_EN
    logic [7:0] r_drop_cnt, r_underrun_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end
        end
    end

    assign tx_drop_count     = r_drop_cnt;
    assign rx_underrun_count = r_underrun_cnt;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign host_data_out  = r_dout;
    assign host_data_oe   = r_oe;
    assign host_tx_full   = r_host_full;
    assign host_rx_empty  = r_host_rx_empty;
    assign tx_overflow    = r_overflow;
    assign rx_underflow   = r_underflow;
    assign rx_enable      = r_en_lvl;
    assign tx_data        = r_tx_data;
    assign tx_load        = r_tx_load;
    assign rx_read_strobe = r_rd_strobe;

endmodule

// File: doc/coax_host_bus_port.md
Name: coax_host_bus_port

Overview:
- Parametrised host-side bus port between the MCU's asynchronous shared data bus and the coax_tx / coax_buffered_rx cores.
- Replaces ad-hoc strobe synchronisers and bus-direction glue with one block containing:
  - configurable synchroniser depth and edge detection;
  - a transmit word FIFO that paces loads into coax_tx;
  - a bus-turnaround state machine;
  - sticky overflow/underflow flags.
- Sits directly under the top level, clocked from the 38 MHz PLL domain.

Parameters:
- DATA_WIDTH, 10, word width on host bus and core interfaces.
- SYNC_STAGES, 2, flops per asynchronous input synchroniser (min 2).
- TX_DEPTH, 16, transmit FIFO depth in words (power of 2, min 2).
- TURNAROUND_CLOCKS, 2, idle clocks between bus release and drive (min 1).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- host_tx_load  in  1  async host write strobe, active on rising edge.
- host_rx_read  in  1  async host read strobe, active on rising edge.
- host_rx_enable  in  1  async; 1 = block drives bus / receive mode.
- host_data_in  in  DATA_WIDTH  bus pad input.
- host_data_out  out  DATA_WIDTH  bus pad output value.
- host_data_oe  out  1  bus pad output enable.
- host_tx_full  out  1  transmit FIFO full.
- host_rx_empty  out  1  registered copy of core rx_empty.
- tx_overflow  out  1  sticky: a load was dropped.
- rx_underflow  out  1  sticky: a read hit an empty receiver.
- rx_enable  out  1  synchronised host_rx_enable, to receiver gate.
- tx_data  out  DATA_WIDTH  word to coax_tx.
- tx_load  out  1  one-clock load pulse to coax_tx.
- tx_full  in  1  coax_tx full.
- rx_data  in  DATA_WIDTH  head word from coax_buffered_rx.
- rx_read_strobe  out  1  one-clock pop pulse to receiver.
- rx_empty  in  1  receiver empty.

Behaviour:
- Reset values: all outputs 0 except host_rx_empty=1. Reset also clears the FIFO, synchronisers, FSM and sticky flags.
- Synchronisers: each async strobe passes SYNC_STAGES flops, then an edge-detect flop. A rising edge yields one internal event pulse SYNC_STAGES+1 clocks after the pin transition.
- Host write:
  - On a load event, sample host_data_in on the same clock. The host keeps data stable from strobe rise for at least SYNC_STAGES+2 clocks.
  - Word is pushed if the FIFO is not full and bus_state is RELEASED.
  - If the FIFO is full, the word is dropped and tx_overflow is set.
  - A load event in any other bus_state is ignored, with no flag.
- host_tx_full is registered: it goes 1 the clock after the push that fills the FIFO and 0 the clock after the pop that frees a slot.
- FIFO drain:
  - When the FIFO is non-empty, tx_full=0 and tx_load was 0 on the previous clock, pop the head. Drive tx_data=head and tx_load=1 for exactly one clock.
  - Minimum load spacing is 2 clocks, covering coax_tx's full latency.
  - A push and a pop on the same clock leave the count unchanged. FIFO pointers wrap modulo TX_DEPTH.
- Bus FSM (bus_state): RELEASED, TURN_ON, DRIVING, TURN_OFF.
  - RELEASED: oe=0. rx_enable=1 → TURN_ON with counter=TURNAROUND_CLOCKS.
  - TURN_ON: oe=0. Counter decrements each clock; at 0 → DRIVING. rx_enable=0 → TURN_OFF.
  - DRIVING: oe=1. rx_enable=0 → TURN_OFF; oe drops on that same clock edge, i.e. registered, one clock after rx_enable falls.
  - TURN_OFF: oe=0. Count TURNAROUND_CLOCKS, then → RELEASED.
- Host read:
  - A read event in DRIVING with rx_empty=0 pulses rx_read_strobe for one clock. host_data_out follows registered rx_data every clock while DRIVING.
  - A read event with rx_empty=1 sets rx_underflow and gives no strobe.
  - A read event outside DRIVING is ignored.
- Reset asserted mid-operation: oe drops immediately (asynchronous), any in-flight tx_load is cancelled and FIFO contents are discarded.

Optional Feature:
- COAX_HOST_PORT_STATS_EN.
- Defined: adds outputs tx_drop_count[7:0] and rx_underrun_count[7:0].
  - Each increments on the same events that set tx_overflow and rx_underflow, saturating at 255.
  - Both reset to 0.
- Undefined: the ports and counters do not exist. Sticky flags are unchanged.

Test Plan:
- Write 3 words (0x001, 0x2AA, 0x3FF) with host_rx_enable=0 and tx_full=0 → tx_load pulses carry the same values in order, pulses ≥2 clocks apart, and the first tx_load occurs SYNC_STAGES+3 clocks after the first strobe edge.
- Hold tx_full=1 and write TX_DEPTH+1 words → host_tx_full=1 after the 16th word, the 17th word is dropped, tx_overflow=1 (drop count=1 with STATS_EN). Release tx_full → 16 words emerge in order.
- Raise host_rx_enable → oe=1 exactly SYNC_STAGES+1+TURNAROUND_CLOCKS+1 clocks later. Lower it → oe=0 after SYNC_STAGES+2 clocks, and a write strobe during TURN_OFF pushes nothing.
- In DRIVING with rx_data=0x155 and rx_empty=0, pulse host_rx_read → single rx_read_strobe and host_data_out=0x155. Repeat with rx_empty=1 → no strobe, rx_underflow=1.
- Assert reset while the FIFO holds 5 words and oe=1 → oe, tx_load and flags are 0 immediately, host_rx_empty=1, and no tx_load occurs after release.
